// File: rtl/pcw_pkg.sv
// Shared definitions for the PCW video memory path.
// Holds the CPU access FSM encoding and the pixel-period slot constants.
package pcw_pkg;

    localparam int unsigned PH_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        DONE = 2'd2
    } vmr_state_t;

    localparam logic [PH_W-1:0] VID_SLOT    = 2'd1;
    localparam logic [PH_W-1:0] VID_CAPTURE = 2'd2;

endpackage

// File: rtl/video_mem_responder.sv
// Shares one pipelined single-port RAM between video fetches and CPU accesses.
// Phase 1 of each pixel period belongs to video; CPU accesses use the other phases.
module video_mem_responder #(
    parameter int unsigned ADDR_W = 17
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ce_pix,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [7:0]        vid_din,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);
    import pcw_pkg::*;

    logic [PH_W-1:0] r_ph_cnt;
    vmr_state_t      r_state;
    logic            r_rd_pend;

    logic [PH_W-1:0] w_ph;
    logic            w_grant;

    // A strobe makes the current cycle phase 0, so odd spacing resynchronises.
    assign w_ph    = ce_pix ? PH_W'(0) : r_ph_cnt;
    assign w_grant = reset_n && (r_state == IDLE) && cpu_req && (w_ph != VID_SLOT);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_ph_cnt  <= '0;
            r_state   <= IDLE;
            r_rd_pend <= 1'b0;
            vid_din   <= '0;
            cpu_rdata <= '0;
            cpu_ack   <= 1'b0;
        end else begin
            r_ph_cnt <= w_ph + PH_W'(1);
            cpu_ack  <= 1'b0;
            if (w_ph == VID_CAPTURE) begin
                vid_din <= ram_rdata;
            end
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_state   <= DATA;
                        r_rd_pend <= ~cpu_we;
                    end
                end
                DATA: begin
                    if (r_rd_pend) begin
                        cpu_rdata <= ram_rdata;
                    end
                    cpu_ack <= 1'b1;
                    r_state <= DONE;
                end
                // No grant here: gives the requester a clock to drop or change cpu_req.
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // RAM bus follows the video address except during a CPU grant cycle.
    always_comb begin
        ram_addr  = vid_addr;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (w_grant) begin
            ram_addr  = cpu_addr;
            ram_we    = cpu_we;
            ram_wdata = cpu_wdata;
        end
    end

endmodule

// File: tb/tb_video_mem_responder.sv
// Scoreboard bench for video_mem_responder with a behavioural 1-clock-latency RAM.
module tb_video_mem_responder;

    localparam int unsigned ADDR_W = 17;
    localparam int unsigned DEPTH  = 131072;

    logic              clk_sys   = 1'b0;
    logic              reset_n   = 1'b0;
    logic              ce_pix    = 1'b0;
    logic [ADDR_W-1:0] vid_addr  = '0;
    logic [7:0]        vid_din;
    logic              cpu_req   = 1'b0;
    logic              cpu_we    = 1'b0;
    logic [ADDR_W-1:0] cpu_addr  = '0;
    logic [7:0]        cpu_wdata = '0;
    logic              cpu_ack;
    logic [7:0]        cpu_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata = '0;

    video_mem_responder #(.ADDR_W(ADDR_W)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ce_pix    (ce_pix),
        .vid_addr  (vid_addr),
        .vid_din   (vid_din),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk_sys = ~clk_sys;

    // RAM model with a backdoor preload port
    logic [7:0]        mem [0:DEPTH-1];
    bit   [7:0]        ref_mem [0:DEPTH-1];
    logic              bd_we   = 1'b0;
    logic [ADDR_W-1:0] bd_addr = '0;
    logic [7:0]        bd_data = '0;

    always @(posedge clk_sys) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_ack = -100;
    logic [1:0] tb_cnt = 2'd0;
    logic [7:0] last_rd = 8'h00;
    logic [7:0] vid_q[$];
    logic [7:0] cpu_q[$];
    int g_sp[8];
    logic [ADDR_W-1:0] g_ad[8];

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) tb_cnt <= 2'd0;
        else          tb_cnt <= (ce_pix ? 2'd0 : tb_cnt) + 2'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected video/CPU data when the DUT presents it
    always @(negedge clk_sys) begin : mon
        logic [1:0] eph;
        eph = ce_pix ? 2'd0 : tb_cnt;
        if (reset_n) begin
            if (ce_pix && vid_q.size() > 0)
                check("vid_din_at_ce", 32'(vid_din), 32'(vid_q.pop_front()));
            if (!ce_pix && eph == 2'd3 && vid_q.size() > 0)
                check("vid_din_at_ph3", 32'(vid_din), 32'(vid_q[0]));
            if (ram_we) begin
                n_cmp++;
                if (eph == 2'd1) begin
                    n_bad++;
                    $display("FAIL ram_we_in_video_slot: got ph %0d required ph!=1", eph);
                end
            end
            if (cpu_ack) begin
                if (cpu_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_cpu_ack: got ack=1 required no ack");
                end else begin
                    check("cpu_rdata", 32'(cpu_rdata), 32'(cpu_q.pop_front()));
                end
                n_cmp++;
                if (cyc - last_ack < 3) begin
                    n_bad++;
                    $display("FAIL ack_spacing: got %0d clocks required >=3", cyc - last_ack);
                end
                last_ack = cyc;
            end
        end
    end

    task automatic poke(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        ref_mem[a] = d;
        @(posedge clk_sys); #1;
        bd_we = 1'b0;
    endtask

    task automatic sync();
        @(posedge clk_sys); #1;
    endtask

    // Issues n pixel periods from g_sp/g_ad, then a closing strobe that checks the last one.
    task automatic gen(input int n);
        for (int i = 0; i < n; i++) begin
            ce_pix = 1'b1;
            vid_addr = g_ad[i];
            @(posedge clk_sys); #1;
            ce_pix = 1'b0;
            vid_q.push_back(ref_mem[vid_addr]);
            repeat (g_sp[i] - 1) @(posedge clk_sys);
            #1;
        end
        ce_pix = 1'b1;
        @(posedge clk_sys); #1;
        ce_pix = 1'b0;
    endtask

    task automatic wait_ph(input logic [1:0] p);
        int k;
        k = 0;
        do begin
            @(posedge clk_sys); #2;
            k++;
        end while (((ce_pix ? 2'd0 : tb_cnt) != p) && k < 16);
        if (k >= 16) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_phase_timeout: got no ph %0d required ph %0d", p, p);
        end
    endtask

    task automatic cpu_op(input logic we, input logic [ADDR_W-1:0] a, input logic [7:0] wd,
                          input logic [7:0] exp_rd, output logic [1:0] ack_ph);
        bit got;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        if (we) begin
            ref_mem[a] = wd;
            cpu_q.push_back(last_rd);
        end else begin
            cpu_q.push_back(exp_rd);
            last_rd = exp_rd;
        end
        got = 1'b0;
        ack_ph = 2'd3;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk_sys);
            if (cpu_ack) begin
                got = 1'b1;
                ack_ph = ce_pix ? 2'd0 : tb_cnt;
            end
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL cpu_ack_timeout: got no ack required ack within 8 clocks");
            cpu_q.delete();
        end
        @(posedge clk_sys); #2;
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] aph;
        // Reset state, with a write request held to prove the bus stays quiet
        vid_addr = 17'h0AAAA;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h00001; cpu_wdata = 8'h77;
        @(negedge clk_sys);
        check("rst_vid_din", 32'(vid_din), 32'h0);
        check("rst_cpu_ack", 32'(cpu_ack), 32'h0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
        check("rst_ram_we", 32'(ram_we), 32'h0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'h0);
        check("rst_ram_addr", 32'(ram_addr), 32'h0AAAA);
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_wdata = 8'h00;
        poke(17'h01234, 8'hA5);
        poke(17'h1FFFF, 8'h3C);
        poke(17'h00100, 8'h11);
        poke(17'h00200, 8'h77);
        poke(17'h00300, 8'h88);
        poke(17'h00400, 8'hC3);
        reset_n = 1'b1;
        repeat (2) sync();

        // Video read
        for (int i = 0; i < 8; i++) begin g_sp[i] = 4; g_ad[i] = 17'h01234; end
        gen(3);

        // CPU read raised in the video slot
        sync();
        fork
            gen(3);
            begin
                wait_ph(2'd1);
                cpu_op(1'b0, 17'h1FFFF, 8'h00, 8'h3C, aph);
                check("ack_phase_ph1_req", 32'(aph), 32'h0);
            end
        join

        // Write during period, video reads it next period
        sync();
        for (int i = 0; i < 8; i++) g_ad[i] = 17'h00100;
        fork
            gen(3);
            begin
                wait_ph(2'd2);
                cpu_op(1'b1, 17'h00100, 8'h5A, 8'h00, aph);
            end
        join

        // Request held continuously with alternating addresses
        sync();
        for (int i = 0; i < 8; i++) g_ad[i] = 17'h01234;
        fork
            gen(8);
            begin
                wait_ph(2'd0);
                cpu_op(1'b0, 17'h00200, 8'h00, 8'h77, aph);
                cpu_op(1'b1, 17'h00300, 8'h99, 8'h00, aph);
                cpu_op(1'b0, 17'h00300, 8'h00, 8'h99, aph);
                cpu_op(1'b1, 17'h00200, 8'h66, 8'h00, aph);
                cpu_op(1'b0, 17'h00200, 8'h00, 8'h66, aph);
                cpu_op(1'b0, 17'h00300, 8'h00, 8'h99, aph);
            end
        join

        // Reset while a read is in DATA
        sync();
        ce_pix = 1'b1; vid_addr = 17'h01234;
        sync();
        ce_pix = 1'b0;
        sync();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h1FFFF; cpu_wdata = 8'hEE;
        sync();
        reset_n = 1'b0;
        @(negedge clk_sys);
        check("midrst_cpu_ack", 32'(cpu_ack), 32'h0);
        check("midrst_cpu_rdata", 32'(cpu_rdata), 32'h0);
        check("midrst_vid_din", 32'(vid_din), 32'h0);
        check("midrst_ram_we", 32'(ram_we), 32'h0);
        check("midrst_ram_addr", 32'(ram_addr), 32'h01234);
        sync();
        cpu_req = 1'b0; cpu_wdata = 8'h00;
        repeat (2) sync();
        reset_n = 1'b1;
        last_rd = 8'h00;
        sync();
        gen(3);

        // Irregular strobe spacing
        sync();
        g_sp[0] = 4; g_ad[0] = 17'h01234;
        g_sp[1] = 5; g_ad[1] = 17'h00100;
        g_sp[2] = 4; g_ad[2] = 17'h00400;
        gen(3);

        repeat (4) sync();
        if (vid_q.size() != 0 || cpu_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending required 0/0", vid_q.size(), cpu_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
